// File: rtl/nn_dense_layer_if.sv
// Stream and weight-memory bus of the dense layer: input beats in, weight reads out, results out.
// The layer itself connects through the slave modport; the environment uses master.
interface nn_dense_layer_if #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 8
);
  localparam int AW = ($clog2(N_OUT * (N_IN + 1)) < 1) ? 1 : $clog2(N_OUT * (N_IN + 1));
  localparam int NW = ($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic [AW-1:0]            weight_addr;
  logic signed [DATA_W-1:0] weight_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [NW-1:0]            out_index;

  modport slave (
    input  in_valid, in_data, weight_data, out_ready,
    output in_ready, weight_addr, out_valid, out_data, out_index
  );

  modport master (
    output in_valid, in_data, weight_data, out_ready,
    input  in_ready, weight_addr, out_valid, out_data, out_index
  );
endinterface

// File: rtl/nn_dense_layer.sv
// Sequential dense layer: buffers one input vector, then one MAC per cycle per neuron with a saturated result.
// Optional macro NN_RELU_EN clamps negative results to zero before output and argmax.
module nn_dense_layer #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  nn_dense_layer_if.slave      bus,
  output logic [7:0]           cifra_iesire,
  output logic                 stare_retea
);
  localparam int AW = ($clog2(N_OUT * (N_IN + 1)) < 1) ? 1 : $clog2(N_OUT * (N_IN + 1));
  localparam int NW = ($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT);
  localparam int CW = ($clog2(N_IN + 1) < 1) ? 1 : $clog2(N_IN + 1);
  localparam int BW = ($clog2(N_IN) < 1) ? 1 : $clog2(N_IN);
  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, ACC, OUT, DONE} state_t;

  state_t                   state_reg;
  logic signed [DATA_W-1:0] in_buf [N_IN];
  logic signed [DATA_W-1:0] x_reg;
  logic [CW-1:0]            cnt_reg;
  logic [NW-1:0]            n_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [AW-1:0]            weight_addr_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;
  logic signed [DATA_W-1:0] out_data_reg;
  logic signed [DATA_W-1:0] best_val_reg;
  logic [NW-1:0]            best_idx_reg;
  logic [7:0]               digit_reg;
  logic                     busy_reg;

  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [DATA_W-1:0] sat;
  logic signed [DATA_W-1:0] result;

  assign prod      = $signed(bus.weight_data) * x_reg;
  assign acc_shift = acc_reg >>> SHIFT;

  always_comb begin
    sat = acc_shift[DATA_W-1:0];
    if (acc_shift > SAT_MAX)
      sat = SAT_MAX[DATA_W-1:0];
    else if (acc_shift < SAT_MIN)
      sat = SAT_MIN[DATA_W-1:0];
  end

`ifdef NN_RELU_EN
  assign result = sat[DATA_W-1] ? '0 : sat;
`else
  assign result = sat;
`endif

  // Input buffer with registered read; x_reg lines up with the weight returned one cycle later.
  always_ff @(posedge clock) begin
    if (enable) begin
      if (state_reg == LOAD && bus.in_valid)
        in_buf[cnt_reg[BW-1:0]] <= bus.in_data;
      x_reg <= in_buf[cnt_reg[BW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      n_reg           <= '0;
      acc_reg         <= '0;
      weight_addr_reg <= '0;
      in_ready_reg    <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      best_val_reg    <= '0;
      best_idx_reg    <= '0;
      digit_reg       <= '0;
      busy_reg        <= 1'b0;
    end else if (enable) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= LOAD;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            if (cnt_reg == CW'(N_IN - 1)) begin
              state_reg       <= MAC;
              in_ready_reg    <= 1'b0;
              cnt_reg         <= '0;
              n_reg           <= '0;
              acc_reg         <= '0;
              weight_addr_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        // cnt_reg is the address index; the data on weight_data belongs to cnt_reg-1.
        MAC: begin
          if (cnt_reg != '0)
            acc_reg <= acc_reg + ACC_W'(prod);
          if (cnt_reg == CW'(N_IN)) begin
            state_reg <= ACC;
          end else begin
            cnt_reg         <= cnt_reg + CW'(1);
            weight_addr_reg <= weight_addr_reg + AW'(1);
          end
        end
        ACC: begin
          acc_reg   <= acc_reg + ACC_W'($signed(bus.weight_data));
          state_reg <= OUT;
        end
        // First OUT cycle registers the saturated result, keeping the accumulator adder off the saturation path.
        OUT: begin
          if (!out_valid_reg) begin
            out_data_reg  <= result;
            out_valid_reg <= 1'b1;
            if (n_reg == '0 || result > best_val_reg) begin
              best_val_reg <= result;
              best_idx_reg <= n_reg;
            end
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (n_reg == NW'(N_OUT - 1)) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg       <= MAC;
              n_reg           <= n_reg + NW'(1);
              cnt_reg         <= '0;
              acc_reg         <= '0;
              weight_addr_reg <= weight_addr_reg + AW'(1);
            end
          end
        end
        DONE: begin
          digit_reg <= 8'(best_idx_reg);
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.weight_addr = weight_addr_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = out_data_reg;
  assign bus.out_index   = n_reg;
  assign cifra_iesire    = digit_reg;
  assign stare_retea     = busy_reg;
endmodule

// File: tb/tb_nn_dense_layer.sv
// Self-checking bench for nn_dense_layer (N_IN=4, N_OUT=3, SHIFT=0) against an arithmetic reference model.
module tb_nn_dense_layer;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int SHIFT  = 0;
  localparam int DEPTH  = N_OUT * (N_IN + 1);

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       start;
  logic [7:0] cifra_iesire;
  logic       stare_retea;

  nn_dense_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W)) bus ();

  nn_dense_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .bus(bus), .cifra_iesire(cifra_iesire), .stare_retea(stare_retea)
  );

  always #5 clock = ~clock;

  logic signed [DATA_W-1:0] x_in [N_IN];
  logic signed [DATA_W-1:0] wmem [DEPTH];
  int exp_out [N_OUT];
  int exp_arg;
  int passes = 0;
  int total  = 0;

  // Weight memory lives in the same clock-enabled system as the layer.
  always @(posedge clock)
    if (enable) bus.weight_data <= wmem[bus.weight_addr];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void model();
    longint s;
    int acc;
    for (int n = 0; n < N_OUT; n++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++)
        s += longint'(wmem[n*(N_IN+1)+i]) * longint'(x_in[i]);
      s += longint'(wmem[n*(N_IN+1)+N_IN]);
      acc = int'(s[31:0]);
      acc = acc >>> SHIFT;
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
`ifdef NN_RELU_EN
      if (acc < 0) acc = 0;
`endif
      exp_out[n] = acc;
    end
    exp_arg = 0;
    for (int n = 1; n < N_OUT; n++)
      if (exp_out[n] > exp_out[exp_arg]) exp_arg = n;
  endfunction

  task automatic set_neuron(input int n, input int w, input int b);
    for (int i = 0; i < N_IN; i++) wmem[n*(N_IN+1)+i] = DATA_W'(w);
    wmem[n*(N_IN+1)+N_IN] = DATA_W'(b);
  endtask

  task automatic run_inf(input int stall_n, input int hold_n);
    int lat;
    int want;
    model();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_load", stare_retea, 1);
    check("in_ready_load", bus.in_ready, 1);
    for (int i = 0; i < N_IN; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clock);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = x_in[i];
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    for (int n = 0; n < N_OUT; n++) begin
      check("addr_base", bus.weight_addr, n * (N_IN + 1));
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 50) begin
        enable = !(n == stall_n && lat >= 2 && lat < 5);
        @(negedge clock);
        lat++;
      end
      enable = 1'b1;
      want = N_IN + 3 + ((n == stall_n) ? 3 : 0);
      check("latency", lat, want);
      check("out_data", $signed(bus.out_data), exp_out[n]);
      check("out_index", bus.out_index, n);
      if (n == hold_n) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", $signed(bus.out_data), exp_out[n]);
          check("hold_index", bus.out_index, n);
          check("hold_addr", bus.weight_addr, n * (N_IN + 1) + N_IN);
        end
      end
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
      check("valid_drop", bus.out_valid, 0);
    end
    check("busy_done", stare_retea, 0);
    @(negedge clock);
    check("argmax", cifra_iesire, exp_arg);
    check("idle_in_ready", bus.in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int seen;
    reset = 1'b0; enable = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) wmem[a] = '0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_weight_addr", bus.weight_addr, 0);
    check("rst_cifra", cifra_iesire, 0);
    check("rst_stare", stare_retea, 0);
    reset = 1'b1;
    @(negedge clock);

    // Basic vector with a held output on neuron 1
    x_in = '{1, 2, 3, 4};
    set_neuron(0, 1, 0); set_neuron(1, -1, 0); set_neuron(2, 2, 5);
    run_inf(-1, 1);

    // Saturation both ways
    x_in = '{127, 127, 127, 127};
    set_neuron(0, 127, 127); set_neuron(1, -128, -128); set_neuron(2, 0, -3);
    run_inf(-1, -1);

    // Tie on 25 goes to the lower index; enable stalls neuron 1
    x_in = '{1, 2, 3, 4};
    set_neuron(0, 2, 5); set_neuron(1, 1, 0); set_neuron(2, 2, 5);
    run_inf(1, -1);

    // Reset in the middle of MAC
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = x_in[i];
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_stare", stare_retea, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_weight_addr", bus.weight_addr, 0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1 || stare_retea === 1'b1) seen++;
    end
    check("abort_quiet", seen, 0);
    run_inf(-1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N_IN; i++) x_in[i] = DATA_W'($urandom);
      for (int a = 0; a < DEPTH; a++)
        wmem[a] = (r % 2 == 0) ? DATA_W'($urandom) : DATA_W'(int'($urandom_range(0, 16)) - 8);
      run_inf((r == 1) ? int'($urandom_range(0, 2)) : -1, (r == 2) ? int'($urandom_range(0, 2)) : -1);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
